// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared constants for the load-store unit memory side: RAM depth and
//   the address map used to steer LSU accesses to DMEM or memory-mapped I/O.
//   No ports (package).
// ---------------------------------------------------------------------------
package lsu_pkg;

    // Data RAM depth in 32-bit words (64 KiB).
    localparam int DMEM_WORDS = 16384;

    // DMEM occupies the bottom 64 KiB of the address space.
    localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DMEM_LIMIT = 32'h0000_FFFF;

    // Each I/O device owns one 4 KiB page.
    localparam logic [31:0] IO_LEDR_BASE = 32'h1000_0000;
    localparam logic [31:0] IO_LEDG_BASE = 32'h1000_1000;
    localparam logic [31:0] IO_HEXL_BASE = 32'h1000_2000;
    localparam logic [31:0] IO_HEXH_BASE = 32'h1000_3000;
    localparam logic [31:0] IO_LCD_BASE  = 32'h1000_4000;
    localparam logic [31:0] SW_BASE      = 32'h1001_0000;

endpackage

// File: rtl/lsu_mem_core_dp_bram_be.sv
// ---------------------------------------------------------------------------
// dp_bram_be
//   Dual-port synchronous RAM, 32-bit words with per-byte write enables,
//   coded so synthesis maps it onto block RAM. Both ports are read/write.
//   Ports:
//     clk, rst_n               clock, synchronous active-low reset (output
//                              registers only; the array is never cleared)
//     addr_a/b [15:0]          byte address; [1:0] ignored, index wraps
//     data_a/b [31:0]          write data, byte-lane aligned
//     wren_a/b [3:0]           byte write enables
//     q_a/b    [31:0]          registered read data (old data on collision)
// ---------------------------------------------------------------------------
module dp_bram_be
    import lsu_pkg::*;
#(
    parameter int WORDS = DMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_a,
    input  logic [31:0] data_a,
    input  logic [3:0]  wren_a,
    output logic [31:0] q_a,
    input  logic [15:0] addr_b,
    input  logic [31:0] data_b,
    input  logic [3:0]  wren_b,
    output logic [31:0] q_b
);

    localparam int AW = $clog2(WORDS);

    logic [AW-1:0] idx_a;
    logic [AW-1:0] idx_b;
    logic [3:0]    we_a;
    logic [3:0]    we_b;

    // Byte offset within the word is not used by the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_a[1:0], addr_b[1:0]};

    assign idx_a = addr_a[AW+1:2];
    assign idx_b = addr_b[AW+1:2];

    // Port B owns any byte both ports write in the same word, so port A's
    // enable for that byte is dropped; this keeps the two write processes
    // disjoint and the result deterministic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        we_a = '0;
        we_b = '0;
        if (rst_n) begin
            we_a = wren_a;
            we_b = wren_b;
            if (idx_a == idx_b) begin
                we_a = wren_a & ~wren_b;
            end
        end
    end

    // NOTE: the array has no reset; clearing it would prevent block-RAM
    // inference, and contents are expected to survive an LSU reset.
    logic [31:0] mem [WORDS];

    // NOTE: non-blocking assignments throughout: the read samples mem before
    // this edge's writes land, which gives the read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a <= '0;
        end else begin
            q_a <= mem[idx_a];
        end
        for (int n = 0; n < 4; n++) begin
            if (we_a[n]) begin
                mem[idx_a][8*n +: 8] <= data_a[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_b <= '0;
        end else begin
            q_b <= mem[idx_b];
        end
        for (int n = 0; n < 4; n++) begin
            if (we_b[n]) begin
                mem[idx_b][8*n +: 8] <= data_b[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_core.sv
// ---------------------------------------------------------------------------
// lsu_mem_core
//   Memory-side core of the load-store unit: dual-port byte-enable data RAM,
//   two-flop switch synchronizer and the DMEM / I/O address decoder.
//   Ports:
//     i_clk, i_reset            clock, synchronous active-low reset
//     i_addr_a/b, i_data_a/b,
//     i_wren_a/b, o_q_a/b       RAM ports A and B (one-cycle read latency)
//     i_io_sw, o_sw_sync        raw switches in, synchronized switches out
//     i_lsu_addr, i_lsu_wren    LSU address / store request to decode
//     o_dmem_valid, o_io_valid,
//     o_dmem_wren               combinational decode results
// ---------------------------------------------------------------------------
module lsu_mem_core
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = lsu_pkg::DMEM_WORDS
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr_a,
    input  logic [31:0] i_data_a,
    input  logic [3:0]  i_wren_a,
    output logic [31:0] o_q_a,
    input  logic [15:0] i_addr_b,
    input  logic [31:0] i_data_b,
    input  logic [3:0]  i_wren_b,
    output logic [31:0] o_q_b,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_sw_sync,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wren,
    output logic        o_dmem_valid,
    output logic        o_io_valid,
    output logic        o_dmem_wren
);

    // ------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------
    dp_bram_be #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .addr_a (i_addr_a),
        .data_a (i_data_a),
        .wren_a (i_wren_a),
        .q_a    (o_q_a),
        .addr_b (i_addr_b),
        .data_b (i_data_b),
        .wren_b (i_wren_b),
        .q_b    (o_q_b)
    );

    // ------------------------------------------------------------------
    // Switch synchronizer: first stage may go metastable, second is used.
    // ------------------------------------------------------------------
    logic [31:0] sw_meta;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sw_meta   <= '0;
            o_sw_sync <= '0;
        end else begin
            sw_meta   <= i_io_sw;
            o_sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Address decoder: device pages are matched on address bits [31:12].
    // ------------------------------------------------------------------
    logic dmem_hit;
    logic io_hit;

    always_comb begin
        dmem_hit = ((i_lsu_addr & ~DMEM_LIMIT) == DMEM_BASE);
        io_hit   = (i_lsu_addr[31:12] == IO_LEDR_BASE[31:12]) ||
                   (i_lsu_addr[31:12] == IO_LEDG_BASE[31:12]) ||
                   (i_lsu_addr[31:12] == IO_HEXL_BASE[31:12]) ||
                   (i_lsu_addr[31:12] == IO_HEXH_BASE[31:12]) ||
                   (i_lsu_addr[31:12] == IO_LCD_BASE[31:12])  ||
                   (i_lsu_addr[31:12] == SW_BASE[31:12]);
    end

    assign o_dmem_valid = dmem_hit;
    assign o_io_valid   = io_hit;
    assign o_dmem_wren  = i_lsu_wren & dmem_hit;

endmodule

// File: tb/tb_lsu_mem_core.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_core
//   Self-checking bench for lsu_mem_core: directed RAM / reset / switch
//   sequences, a decoder vector table, and randomized traffic compared with
//   a word-array RAM model, a switch delay queue and an address-range
//   decoder model.
// ---------------------------------------------------------------------------
module tb_lsu_mem_core;

    localparam int WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  wren_a, wren_b;
    logic [31:0] q_a, q_b;
    logic [31:0] io_sw, sw_sync;
    logic [31:0] lsu_addr;
    logic        lsu_wren;
    logic        dmem_valid, io_valid, dmem_wren;

    always #5 clk = ~clk;

    lsu_mem_core #(
        .DMEM_WORDS (WORDS)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_addr_a     (addr_a),
        .i_data_a     (data_a),
        .i_wren_a     (wren_a),
        .o_q_a        (q_a),
        .i_addr_b     (addr_b),
        .i_data_b     (data_b),
        .i_wren_b     (wren_b),
        .o_q_b        (q_b),
        .i_io_sw      (io_sw),
        .o_sw_sync    (sw_sync),
        .i_lsu_addr   (lsu_addr),
        .i_lsu_wren   (lsu_wren),
        .o_dmem_valid (dmem_valid),
        .o_io_valid   (io_valid),
        .o_dmem_wren  (dmem_wren)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [WORDS];
    logic [31:0] sw_q [$];

    typedef struct {
        logic [31:0] addr;
        logic        wren;
        logic        exp_dmem;
        logic        exp_io;
        logic        exp_wren;
    } dec_vec_t;

    dec_vec_t dec_tab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / 4) % WORDS;
    endfunction

    // One RAM cycle: drive both ports, predict the registered read data from
    // the model's pre-write contents, then apply byte writes A first and B
    // second so B wins overlapping bytes. Nothing is written while in reset.
    task automatic ram_cycle(input string tag,
                             input logic [15:0] aa, input logic [31:0] da, input logic [3:0] wa,
                             input logic [15:0] ab, input logic [31:0] db, input logic [3:0] wb);
        int ia, ib;
        logic [31:0] ea, eb;
        addr_a = aa; data_a = da; wren_a = wa;
        addr_b = ab; data_b = db; wren_b = wb;
        ia = word_of(aa);
        ib = word_of(ab);
        if (!rst_n) begin
            ea = 32'h0;
            eb = 32'h0;
        end else begin
            ea = model[ia];
            eb = model[ib];
            for (int n = 0; n < 4; n++) if (wa[n]) model[ia][8*n +: 8] = da[8*n +: 8];
            for (int n = 0; n < 4; n++) if (wb[n]) model[ib][8*n +: 8] = db[8*n +: 8];
        end
        @(posedge clk);
        #1;
        check({tag, "_q_a"}, q_a, ea);
        check({tag, "_q_b"}, q_b, eb);
    endtask

    task automatic idle(input string tag);
        ram_cycle(tag, 16'h0100, 32'h0, 4'h0, 16'h0104, 32'h0, 4'h0);
    endtask

    // Address-range view of the memory map.
    function automatic logic [2:0] dec_ref(input logic [31:0] a, input logic w);
        logic d, io;
        d  = (a < 32'h0001_0000);
        io = (a >= 32'h1000_0000 && a < 32'h1000_5000) ||
             (a >= 32'h1001_0000 && a < 32'h1001_1000);
        return {d, io, w & d};
    endfunction

    initial begin
        logic [2:0]  exp_dec;
        logic [15:0] ra, rb;
        logic [31:0] v;

        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;

        dec_tab[0]  = '{32'h0000_FFFC, 1'b1, 1'b1, 1'b0, 1'b1};
        dec_tab[1]  = '{32'h1000_4000, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tab[2]  = '{32'h1001_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tab[3]  = '{32'h1000_5000, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_tab[4]  = '{32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_tab[5]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        dec_tab[6]  = '{32'h1000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        dec_tab[7]  = '{32'h1000_4FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tab[8]  = '{32'h0FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_tab[9]  = '{32'h1001_0FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tab[10] = '{32'h1001_1000, 1'b0, 1'b0, 1'b0, 1'b0};
        dec_tab[11] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};

        lsu_addr = 32'h0;
        lsu_wren = 1'b0;

        // Reset for two edges with switches high and writes requested.
        rst_n = 1'b0;
        io_sw = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            ram_cycle("rst_init", 16'h0010, 32'h1234_5678, 4'hF, 16'h0014, 32'h9ABC_DEF0, 4'hF);
            check("rst_init_sw", sw_sync, 32'h0);
        end
        rst_n = 1'b1;
        io_sw = 32'h0;

        // Clear the 64-word window used below, two words per cycle.
        for (int i = 0; i < 32; i++) begin
            ram_cycle("clear", 16'(i * 8), 32'h0, 4'hF, 16'(i * 8 + 4), 32'h0, 4'hF);
        end
        check("sw_idle", sw_sync, 32'h0);

        // Switch latency: change, then exactly two edges.
        io_sw = 32'h0000_03FF;
        idle("sw1");
        check("sw_edge1", sw_sync, 32'h0);
        idle("sw2");
        check("sw_edge2", sw_sync, 32'h0000_03FF);

        // Full-word write then read-back.
        ram_cycle("wr_full", 16'h0010, 32'hDEAD_BEEF, 4'hF, 16'h0100, 32'h0, 4'h0);
        ram_cycle("rd_full", 16'h0010, 32'h0, 4'h0, 16'h0100, 32'h0, 4'h0);
        check("full_word", q_a, 32'hDEAD_BEEF);

        // Byte enables from both ports on one word.
        ram_cycle("be_init", 16'h0020, 32'h1122_3344, 4'hF, 16'h0020, 32'h0, 4'h0);
        ram_cycle("be_wr", 16'h0020, 32'h0000_00AA, 4'b0001, 16'h0020, 32'hBB00_0000, 4'b1000);
        ram_cycle("be_rd", 16'h0020, 32'h0, 4'h0, 16'h0020, 32'h0, 4'h0);
        check("byte_en_a", q_a, 32'hBB22_33AA);
        check("byte_en_b", q_b, 32'hBB22_33AA);

        // Overlapping bytes: port B wins.
        ram_cycle("ovl_full", 16'h0024, 32'h0101_0101, 4'hF, 16'h0024, 32'h0202_0202, 4'hF);
        ram_cycle("ovl_part", 16'h0028, 32'hAAAA_AAAA, 4'b0011, 16'h002A, 32'hBBBB_BBBB, 4'b0110);
        ram_cycle("ovl_rd", 16'h0024, 32'h0, 4'h0, 16'h0028, 32'h0, 4'h0);
        check("overlap_full", q_a, 32'h0202_0202);
        check("overlap_part", q_b, 32'h00BB_BBAA);

        // Misaligned pair across two consecutive words.
        ram_cycle("mis_init", 16'h0040, 32'h1111_1111, 4'hF, 16'h0044, 32'h2222_2222, 4'hF);
        ram_cycle("mis_wr", 16'h0040, 32'h7800_0000, 4'b1000, 16'h0044, 32'h0012_3456, 4'b0111);
        check("mis_old_a", q_a, 32'h1111_1111);
        check("mis_old_b", q_b, 32'h2222_2222);
        ram_cycle("mis_rd", 16'h0040, 32'h0, 4'h0, 16'h0044, 32'h0, 4'h0);
        check("mis_new_a", q_a, 32'h7811_1111);
        check("mis_new_b", q_b, 32'h2212_3456);

        // Cross-port read-during-write returns old data.
        ram_cycle("xrw_wr", 16'h0050, 32'hCAFE_F00D, 4'hF, 16'h0050, 32'h0, 4'h0);
        check("xport_old", q_b, 32'h0);
        ram_cycle("xrw_rd", 16'h0060, 32'h0, 4'h0, 16'h0050, 32'h0, 4'h0);
        check("xport_new", q_b, 32'hCAFE_F00D);

        // Mid-run reset: outputs clear, RAM keeps data, writes are ignored.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ram_cycle("rst_mid", 16'h0010, 32'h0, 4'hF, 16'h0014, 32'hFFFF_FFFF, 4'hF);
            check("rst_mid_sw", sw_sync, 32'h0);
        end
        rst_n = 1'b1;
        ram_cycle("rst_keep", 16'h0010, 32'h0, 4'h0, 16'h0014, 32'h0, 4'h0);
        check("rst_keep_a", q_a, 32'hDEAD_BEEF);
        check("rst_ignored_wr_b", q_b, 32'h0);
        check("rst_sw_edge1", sw_sync, 32'h0);
        idle("rst_sw");
        check("rst_sw_edge2", sw_sync, 32'h0000_03FF);

        // Decoder vector table.
        for (int i = 0; i < 12; i++) begin
            lsu_addr = dec_tab[i].addr;
            lsu_wren = dec_tab[i].wren;
            #1;
            check($sformatf("dec%0d_dmem_valid", i), 32'(dmem_valid), 32'(dec_tab[i].exp_dmem));
            check($sformatf("dec%0d_io_valid", i), 32'(io_valid), 32'(dec_tab[i].exp_io));
            check($sformatf("dec%0d_dmem_wren", i), 32'(dmem_wren), 32'(dec_tab[i].exp_wren));
        end

        // Randomized traffic: RAM window, switches, decoder.
        sw_q.delete();
        sw_q.push_back(32'h0000_03FF);
        for (int it = 0; it < 400; it++) begin
            ra = {8'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            rb = ($urandom_range(0, 3) == 0) ? {ra[15:2], 2'($urandom)}
                                             : {8'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            v = $urandom;
            io_sw = v;
            sw_q.push_back(v);
            ram_cycle("rnd",
                      ra, $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                      rb, $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
            check("rnd_sw", sw_sync, sw_q.pop_front());

            case ($urandom_range(0, 3))
                0:       lsu_addr = $urandom;
                1:       lsu_addr = 32'h0000_0000 + 32'($urandom_range(0, 32'h1FFFF));
                2:       lsu_addr = 32'h1000_0000 + 32'($urandom_range(0, 32'hFFFF));
                default: lsu_addr = 32'h1001_0000 + 32'($urandom_range(0, 32'h1FFF));
            endcase
            lsu_wren = 1'($urandom);
            #1;
            exp_dec = dec_ref(lsu_addr, lsu_wren);
            check("rnd_dec", {29'h0, dmem_valid, io_valid, dmem_wren}, {29'h0, exp_dec});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
